chacha_block_engine: RTL and testbench
======================================

// Module: chacha_block_engine
// PURPOSE
//  Iterative ChaCha block function (RFC 8439 state layout). Accepts key, nonce and
//  block counter over a valid/ready handshake. Runs ROUNDS rounds using QR_PER_CYCLE
//  parallel chacha_qr instances per clock, then adds the initial state back in.
//  Presents one 512-bit keystream block, held under backpressure. Sits between the
//  cipher control/counter logic and the XOR datapath.
// PARAMETERS
//  ROUNDS        20  total rounds; even, >=2 (8/12/20 in use); else elaboration error
//  QR_PER_CYCLE  1   quarterrounds per clock; one of 1,2,4; else elaboration error
// PORTS
//  clk        in   1    sole clock, rising edge
//  reset_n    in   1    asynchronous active-low reset
//  key        in   256  key words k0..k7; k_i = key[255-32i -: 32], word-level, no byte swap
//  nonce      in   96   n0..n2; n_i = nonce[95-32i -: 32]
//  ctr        in   32   block counter word
//  in_valid   in   1    request valid
//  in_ready   out  1    engine idle, can accept
//  block_out  out  512  keystream word x_i = block_out[511-32i -: 32]
//  out_valid  out  1    block_out valid
//  out_ready  in   1    consumer accepts block
// BEHAVIOUR
//  - Reset: FSM=IDLE, state/init/output regs=0, out_valid=0, block_out=0, round ctr=0.
//    in_ready is 1 once reset_n is high. Reset mid-operation aborts the computation
//    immediately; no partial block is ever emitted.
//  - Initial state: x0..3 = 61707865,3320646e,79622d32,6b206574; x4..11 = k0..k7;
//    x12 = ctr; x13..15 = n0..n2.
//  - FSM IDLE: in_ready=1. Accept when in_valid&&in_ready. The accept loads the
//    working and init state and moves the FSM to ROUND. key/nonce/ctr are sampled
//    only at accept.
//  - FSM ROUND: in_ready=0. Each cycle applies QR_PER_CYCLE quarterrounds of the
//    current half-round.
//    Column groups: (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15).
//    Diagonal groups: (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
//    Groups are taken in listed order; P=QR_PER_CYCLE consecutive groups per cycle.
//    Groups in one cycle are disjoint, so no intra-cycle hazards.
//    Odd rounds (1st,3rd,..) are column rounds; even rounds are diagonal rounds.
//    A step counter runs 0..ROUNDS*4/P-1. It is sized $clog2(ROUNDS*4/P) and wraps
//    to 0 on leaving ROUND.
//  - Finalise: on the last step, the FSM goes to DONE. In the same edge:
//    block_out_i = (x_i after final QR) + init_i, mod 2^32 per word, carries discarded.
//  - FSM DONE: out_valid=1 and block_out is stable until out_valid&&out_ready.
//    That handshake returns the FSM to IDLE; out_valid drops next cycle and
//    block_out keeps its value. in_ready=0 in DONE, so no accept in the handshake cycle.
//  - Latency: accept at edge T gives out_valid high after edge T+ROUNDS*4/P.
//    Example: 80 cycles for 20/1, 20 for 20/4, 32 for 8/1.
//  - in_valid while busy is ignored (no queueing). Throughput is 1 block per
//    ROUNDS*4/P+2 cycles with out_ready tied high.
//  - ctr is not incremented internally; the caller owns counter/overflow policy.
// STRUCTURE
//  - chacha_pkg: SIGMA constants; 8x4 QR group index table; state typedef
//    (16 x 32-bit).
//  - Sub-module: chacha_qr (existing combinational quarterround), QR_PER_CYCLE
//    instances in a generate loop.
//  - Muxing: input muxes select group operands from the step index; write-back is
//    by matching index.
//  - Body: one FSM (IDLE/ROUND/DONE), step counter, 512b working, init and output regs.
// TESTING
//  1. chacha_qr vector, RFC 8439 2.1.1:
//     a,b,c,d = 11111111,01020304,9b8d6f43,01234567 -> ea2a92f4,cb1cf8ce,4581472e,5881c4bb.
//  2. RFC 8439 2.3.2, ROUNDS=20, all P in {1,2,4}:
//     Inputs: key words 03020100..1f1e1d1c, ctr=1, nonce 09000000,4a000000,00000000.
//     Expected: x0=e4e7f110, x1=15593bd1, x15=4e3c50a2. Latency is exactly 80/40/20.
//  3. Backpressure: hold out_ready=0 for 50 cycles. out_valid stays 1, block_out is
//     unchanged, and pulsing in_valid is ignored. out_ready=1 returns the FSM to IDLE
//     next cycle.
//  4. Async reset at step 37 mid-ROUND: out_valid/block_out are 0 at once. After
//     release a fresh test-2 request yields the correct block.
//  5. Back-to-back: in_valid and out_ready tied 1 with ctr 1,2,3. Three blocks
//     arrive, each ROUNDS*4/P+2 cycles apart. Block for ctr=2 matches the golden model.
//  6. ROUNDS=8 and 12 with random key/nonce/ctr (1000 each) vs C reference model,
//     including ctr=ffffffff. Word adds must wrap mod 2^32.

Source files
------------

// File: rtl/chacha_pkg.sv
// ----------------------------------------------------------------------------
// chacha_pkg
//   Shared types and constants for the iterative ChaCha block engine.
//   - state_t : 16 x 32-bit ChaCha state, word 0 in the most significant slot
//               so that a flat 512-bit view reads x0..x15 from MSB to LSB.
//   - quad_t  : the four operands (a,b,c,d) of one quarterround, a in MSB.
//   - fsm_t   : engine control states.
//   - SIGMA   : "expand 32-byte k" constant words x0..x3.
//   - QR_IDX  : state word indices for the 8 quarterround groups, the four
//               column groups first, then the four diagonal groups.
// ----------------------------------------------------------------------------
package chacha_pkg;

    typedef logic [0:15][31:0] state_t;
    typedef logic [0:3][31:0]  quad_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [0:3][31:0] SIGMA = {
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    localparam logic [0:7][0:3][3:0] QR_IDX = {
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15,
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    // Word order of the flat inputs already matches the state layout
    // (k0 and n0 sit in the top bits), so plain concatenation builds x0..x15.
    function automatic state_t init_state(input logic [255:0] key,
                                          input logic [95:0]  nonce,
                                          input logic [31:0]  ctr);
        return {SIGMA, key, ctr, nonce};
    endfunction

    // Per-word addition mod 2^32; carries never cross word boundaries.
    function automatic state_t add_state(input state_t a, input state_t b);
        state_t r;
        for (int i = 0; i < 16; i++) begin
            r[i] = a[i] + b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// ----------------------------------------------------------------------------
// chacha_qr
//   Combinational ChaCha quarterround.
//   Ports:
//     words  in  4x32  operands a,b,c,d (a in the most significant word)
//     result out 4x32  updated a,b,c,d in the same order
// ----------------------------------------------------------------------------
module chacha_qr
    import chacha_pkg::*;
(
    input  quad_t words,
    output quad_t result
);

    logic [31:0] a, b, c, d;

    // NOTE: blocking assignments are intended here; each line consumes the
    // value produced by the line above within a single combinational pass.
    always_comb begin
        a = words[0];
        b = words[1];
        c = words[2];
        d = words[3];
        a = a + b;  d = d ^ a;  d = {d[15:0], d[31:16]};
        c = c + d;  b = b ^ c;  b = {b[19:0], b[31:20]};
        a = a + b;  d = d ^ a;  d = {d[23:0], d[31:24]};
        c = c + d;  b = b ^ c;  b = {b[24:0], b[31:25]};
        result = {a, b, c, d};
    end

endmodule

// File: rtl/chacha_block_engine.sv
// ----------------------------------------------------------------------------
// chacha_block_engine
//   Iterative ChaCha block function. A request (key, nonce, ctr) is accepted
//   over in_valid/in_ready, ROUNDS rounds are computed with QR_PER_CYCLE
//   quarterrounds per clock, the initial state is added back and the 512-bit
//   keystream block is presented over out_valid/out_ready, held under
//   backpressure.
//   Ports:
//     clk        in   1    rising-edge clock
//     reset_n    in   1    asynchronous active-low reset
//     key        in   256  k0..k7, k_i = key[255-32i -: 32]
//     nonce      in   96   n0..n2, n_i = nonce[95-32i -: 32]
//     ctr        in   32   block counter word (never incremented here)
//     in_valid   in   1    request valid
//     in_ready   out  1    engine idle and able to accept
//     block_out  out  512  keystream, x_i = block_out[511-32i -: 32]
//     out_valid  out  1    block_out valid
//     out_ready  in   1    consumer accepts the block
// ----------------------------------------------------------------------------
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  ctr,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         out_valid,
    input  logic         out_ready
);

    generate
        if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("chacha_block_engine: ROUNDS must be even and >= 2");
        end
        if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qr
            $error("chacha_block_engine: QR_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int STEPS_PER_ROUND = 4 / QR_PER_CYCLE;
    localparam int STEPS           = ROUNDS * STEPS_PER_ROUND;
    localparam int STEP_W          = $clog2(STEPS);

    fsm_t              state, state_next;
    logic [STEP_W-1:0] step;
    logic              accept;
    logic              last_step;

    state_t work, work_next;
    state_t init;
    state_t out_reg;

    logic [2:0] grp_base;
    logic [2:0] grp       [QR_PER_CYCLE];
    quad_t      qr_words  [QR_PER_CYCLE];
    quad_t      qr_result [QR_PER_CYCLE];

    assign last_step = (state == ROUND) && (step == STEP_W'(STEPS - 1));
    assign block_out = out_reg;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for every register so all flops
            // update together from pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- operand selection ----------------
    // Within a round the step walks P groups at a time; the round parity
    // (step / STEPS_PER_ROUND) picks column (even) or diagonal (odd) groups.
    // Both divisors are powers of two, so this reduces to bit slicing.
    always_comb begin
        grp_base = 3'(((int'(step) / STEPS_PER_ROUND) % 2) * 4
                      + (int'(step) % STEPS_PER_ROUND) * QR_PER_CYCLE);
        for (int i = 0; i < QR_PER_CYCLE; i++) begin
            grp[i] = grp_base + 3'(i);
            for (int k = 0; k < 4; k++) begin
                qr_words[i][k] = work[QR_IDX[grp[i]][k]];
            end
        end
    end

    for (genvar i = 0; i < QR_PER_CYCLE; i++) begin : g_qr
        chacha_qr u_qr (
            .words  (qr_words[i]),
            .result (qr_result[i])
        );
    end

    // Groups processed in one cycle touch disjoint words, so write-back
    // by index never collides.
    always_comb begin
        work_next = work;
        for (int i = 0; i < QR_PER_CYCLE; i++) begin
            for (int k = 0; k < 4; k++) begin
                work_next[QR_IDX[grp[i]][k]] = qr_result[i][k];
            end
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: the wide state registers are reset too, so a reset mid-block
    // clears block_out at once and no stale keystream can be observed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work    <= '0;
            init    <= '0;
            out_reg <= '0;
            step    <= '0;
        end else if (accept) begin
            work <= init_state(key, nonce, ctr);
            init <= init_state(key, nonce, ctr);
            step <= '0;
        end else if (state == ROUND) begin
            work <= work_next;
            if (last_step) begin
                step    <= '0;
                out_reg <= add_state(work_next, init);
            end else begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// ----------------------------------------------------------------------------
// tb_chacha_block_engine
//   Self-checking bench for chacha_block_engine. Several engine instances with
//   different ROUNDS/QR_PER_CYCLE share the request buses; each has its own
//   handshake signals. A standalone chacha_qr instance covers the quarterround.
// ----------------------------------------------------------------------------
module tb_chacha_block_engine;
    import chacha_pkg::*;

    localparam int NCFG = 5;
    localparam int CFG_R [NCFG] = '{20, 20, 20, 8, 12};
    localparam int CFG_P [NCFG] = '{1, 2, 4, 1, 4};

    localparam logic [255:0] RFC_KEY = {
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c
    };
    localparam logic [95:0] RFC_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};

    logic         clk;
    logic         reset_n;
    logic [255:0] key_b;
    logic [95:0]  nonce_b;
    logic [31:0]  ctr_b;
    logic         in_valid  [NCFG];
    logic         in_ready  [NCFG];
    logic         out_valid [NCFG];
    logic         out_ready [NCFG];
    logic [511:0] block_out [NCFG];

    quad_t qr_in, qr_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [511:0] sb_q[$];
    int           out_times[$];
    bit           mon_en = 1'b0;
    int           mon_d  = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        chacha_block_engine #(
            .ROUNDS       (CFG_R[g]),
            .QR_PER_CYCLE (CFG_P[g])
        ) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .key       (key_b),
            .nonce     (nonce_b),
            .ctr       (ctr_b),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .block_out (block_out[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
        );
    end

    chacha_qr u_qr (
        .words  (qr_in),
        .result (qr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", checks);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [127:0] qr_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        a += b; d ^= a; d = rotl(d, 16);
        c += d; b ^= c; b = rotl(b, 12);
        a += b; d ^= a; d = rotl(d, 8);
        c += d; b ^= c; b = rotl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_ref(input int rounds, input logic [255:0] k,
                                                input logic [95:0] n, input logic [31:0] c);
        logic [31:0]  x [16];
        logic [31:0]  s [16];
        logic [511:0] flat;
        logic [511:0] r;
        flat = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, k, c, n};
        for (int i = 0; i < 16; i++) begin
            s[i] = flat[511-32*i -: 32];
            x[i] = s[i];
        end
        for (int dr = 0; dr < rounds; dr += 2) begin
            {x[0], x[4], x[8],  x[12]} = qr_ref(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr_ref(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr_ref(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr_ref(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr_ref(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr_ref(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr_ref(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr_ref(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && out_valid[mon_d] && out_ready[mon_d]) begin
            out_times.push_back(cyc);
            check("sb_expected_pending", 512'(sb_q.size() != 0), 512'(1));
            if (sb_q.size() != 0) check("sb_block", block_out[mon_d], sb_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    // Returns at the negedge after the accepting edge; t_acc is that edge's number.
    task automatic do_accept(input int d, input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c, output int t_acc);
        bit ok = 1'b0;
        @(negedge clk);
        key_b = k; nonce_b = n; ctr_b = c;
        in_valid[d] = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready[d]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept_within_budget", 512'(ok), 512'(1));
        if (ok) begin
            t_acc = cyc + 1;
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int t_out);
        bit ok = 1'b0;
        t_out = -1;
        for (int i = 0; i < 400; i++) begin
            if (out_valid[d]) begin ok = 1'b1; t_out = cyc; break; end
            @(negedge clk);
        end
        check("out_valid_within_budget", 512'(ok), 512'(1));
    endtask

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        bit           has_words;
        logic [31:0]  x0, x1, x15;
        int           latency;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input int idx);
        int ta, to;
        vec_t v = vecs[idx];
        out_ready[v.d] = 1'b1;
        do_accept(v.d, v.key, v.nonce, v.ctr, ta);
        wait_out(v.d, to);
        check($sformatf("vec%0d_latency", idx), 512'(to - ta), 512'(v.latency));
        if (v.has_words) begin
            check($sformatf("vec%0d_x0", idx),  512'(block_out[v.d][511 -: 32]), 512'(v.x0));
            check($sformatf("vec%0d_x1", idx),  512'(block_out[v.d][479 -: 32]), 512'(v.x1));
            check($sformatf("vec%0d_x15", idx), 512'(block_out[v.d][31:0]),      512'(v.x15));
        end
        check($sformatf("vec%0d_block", idx), block_out[v.d],
              chacha_ref(CFG_R[v.d], v.key, v.nonce, v.ctr));
        @(negedge clk);
        check($sformatf("vec%0d_valid_drop", idx), 512'(out_valid[v.d]), 512'(0));
        check($sformatf("vec%0d_ready_back", idx), 512'(in_ready[v.d]), 512'(1));
    endtask

    initial begin
        int           ta, to;
        bit           bad;
        logic [511:0] snap;
        logic [255:0] rk;
        logic [95:0]  rn;
        logic [31:0]  rc;

        vecs[0] = '{0, RFC_KEY, RFC_NONCE, 32'd1, 1'b1, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 80};
        vecs[1] = '{1, RFC_KEY, RFC_NONCE, 32'd1, 1'b1, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 40};
        vecs[2] = '{2, RFC_KEY, RFC_NONCE, 32'd1, 1'b1, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 20};
        vecs[3] = '{3, RFC_KEY, RFC_NONCE, 32'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32};
        vecs[4] = '{4, RFC_KEY, RFC_NONCE, 32'hffffffff, 1'b0, 32'h0, 32'h0, 32'h0, 12};

        reset_n = 1'b0;
        key_b = '0; nonce_b = '0; ctr_b = '0;
        for (int d = 0; d < NCFG; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end

        // Quarterround vector
        qr_in = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
        #1;
        check("qr_vector", 512'(qr_out),
              512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < NCFG; d++) begin
            check($sformatf("rst%0d_out_valid", d), 512'(out_valid[d]), 512'(0));
            check($sformatf("rst%0d_block", d), block_out[d], 512'(0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NCFG; d++) begin
            check($sformatf("rel%0d_in_ready", d), 512'(in_ready[d]), 512'(1));
        end

        // RFC vector on every P plus latency of the short-round instances
        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure, with request inputs disturbed after accept
        out_ready[0] = 1'b0;
        do_accept(0, RFC_KEY, RFC_NONCE, 32'd1, ta);
        key_b = ~RFC_KEY; nonce_b = ~RFC_NONCE; ctr_b = 32'hdeadbeef;
        wait_out(0, to);
        check("bp_latency", 512'(to - ta), 512'(80));
        snap = block_out[0];
        check("bp_block", snap, chacha_ref(20, RFC_KEY, RFC_NONCE, 32'd1));
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            in_valid[0] = (c >= 10 && c <= 12);
            if (!out_valid[0] || block_out[0] !== snap || in_ready[0]) bad = 1'b1;
        end
        check("bp_hold_stable", 512'(bad), 512'(0));
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 512'(out_valid[0]), 512'(0));
        check("bp_release_ready", 512'(in_ready[0]), 512'(1));
        check("bp_release_block", block_out[0], snap);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid[0]) bad = 1'b1;
        end
        check("bp_no_queued_request", 512'(bad), 512'(0));

        // Async reset mid-ROUND at step 37
        do_accept(0, RFC_KEY, RFC_NONCE, 32'd1, ta);
        repeat (37) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 512'(out_valid[0]), 512'(0));
        check("midrst_block", block_out[0], 512'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 512'(in_ready[0]), 512'(1));
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid[0] || block_out[0] !== 512'(0)) bad = 1'b1;
        end
        check("midrst_no_partial", 512'(bad), 512'(0));
        run_vec(0);

        // Back-to-back with in_valid and out_ready tied high
        out_times.delete();
        sb_q.delete();
        mon_d  = 0;
        mon_en = 1'b1;
        key_b = RFC_KEY; nonce_b = RFC_NONCE;
        @(negedge clk);
        in_valid[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bit ok = 1'b0;
            ctr_b = 32'(b + 1);
            for (int i = 0; i < 300; i++) begin
                if (in_ready[0]) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check($sformatf("b2b_accept%0d", b), 512'(ok), 512'(1));
            sb_q.push_back(chacha_ref(20, RFC_KEY, RFC_NONCE, 32'(b + 1)));
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        for (int i = 0; i < 300 && out_times.size() < 3; i++) @(negedge clk);
        check("b2b_block_count", 512'(out_times.size()), 512'(3));
        if (out_times.size() == 3) begin
            check("b2b_spacing01", 512'(out_times[1] - out_times[0]), 512'(82));
            check("b2b_spacing12", 512'(out_times[2] - out_times[1]), 512'(82));
        end
        @(negedge clk);
        mon_en = 1'b0;

        // Random requests on the 8- and 12-round instances
        for (int d = 3; d <= 4; d++) begin
            sb_q.delete();
            mon_d  = d;
            mon_en = 1'b1;
            out_ready[d] = 1'b1;
            for (int n = 0; n < 1000; n++) begin
                rk = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
                rn = {$urandom, $urandom, $urandom};
                rc = $urandom;
                if (n == 0) rc = 32'hffffffff;
                if (n == 1) begin rk = '1; rn = '1; rc = 32'hffffffff; end
                sb_q.push_back(chacha_ref(CFG_R[d], rk, rn, rc));
                do_accept(d, rk, rn, rc, ta);
            end
            for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
            check($sformatf("rand%0d_drained", d), 512'(sb_q.size()), 512'(0));
            @(negedge clk);
            mon_en = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
